// File: rtl/refill_fifo_pkg.sv
// Shared constants and entry types for the cache-refill read-beat FIFO.
package refill_fifo_pkg;

    localparam int REFILL_FIFO_DEPTH = 8;
    localparam int REFILL_DATA_W     = 64;

    // Entry layout {error, last, data} for the 64-bit instance.
    typedef struct packed {
        logic                     error;
        logic                     last;
        logic [REFILL_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/refill_fifo_mem.sv
// Entry storage for refill_fifo: one write port, one asynchronous read port, no reset.
module refill_fifo_mem
    import refill_fifo_pkg::*;
#(
    parameter int ENTRY_W = REFILL_DATA_W + 2,
    parameter int DEPTH   = REFILL_FIFO_DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_entry,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_entry
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/refill_fifo.sv
// First-word fall-through FIFO for refill read beats {error, last, data}.
// Define REFILL_FIFO_BURST_CNT_EN to count complete bursts held in burst_cnt.
module refill_fifo
    import refill_fifo_pkg::*;
#(
    parameter int DATA_W = REFILL_DATA_W,
    parameter int DEPTH  = REFILL_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_last,
    input  logic                       wr_error,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_last,
    output logic                       rd_error,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_seen,
    output logic [$clog2(DEPTH+1)-1:0] burst_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = DATA_W + 2;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    // Pointer MSB is the wrap bit; DEPTH is a power of two so +1 wraps naturally.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign push     = wr_valid && wr_ready && !flush;
    assign pop      = rd_valid && rd_ready && !flush;

    assign wr_entry                     = {wr_error, wr_last, wr_data};
    assign {rd_error, rd_last, rd_data} = rd_entry;

    refill_fifo_mem #(
        .ENTRY_W (EW),
        .DEPTH   (DEPTH),
        .ADDR_W  (AW)
    ) u_mem (
        .clk      (clk),
        .wr_en    (push),
        .wr_addr  (wr_ptr[AW-1:0]),
        .wr_entry (wr_entry),
        .rd_addr  (rd_ptr[AW-1:0]),
        .rd_entry (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_seen <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && wr_error) begin
                err_seen <= 1'b1;
            end
        end
    end

`ifdef REFILL_FIFO_BURST_CNT_EN
    logic burst_in;
    logic burst_out;

    assign burst_in  = push && wr_last;
    assign burst_out = pop && rd_last;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            burst_cnt <= '0;
        end else begin
            case ({burst_in, burst_out})
                2'b10:   burst_cnt <= burst_cnt + CW'(1);
                2'b01:   burst_cnt <= burst_cnt - CW'(1);
                default: burst_cnt <= burst_cnt;
            endcase
        end
    end
`else
    assign burst_cnt = '0;
`endif

endmodule

// File: tb/tb_refill_fifo.sv
// Self-checking bench for refill_fifo: directed cases plus random traffic against a queue model.
module tb_refill_fifo;
    import refill_fifo_pkg::*;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);

`ifdef REFILL_FIFO_BURST_CNT_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              wr_error;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_error;
    logic [CW-1:0]     count;
    logic              err_seen;
    logic [CW-1:0]     burst_cnt;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    fifo_entry_t model_q[$];
    bit          model_err;

    refill_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .wr_error  (wr_error),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .rd_error  (rd_error),
        .count     (count),
        .err_seen  (err_seen),
        .burst_cnt (burst_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int model_bursts();
        int n = 0;
        foreach (model_q[i]) if (model_q[i].last) n++;
        return n;
    endfunction

    // Reference: queue of held beats; a burst is held for every queued last beat.
    always @(posedge clk) begin
        bit do_push;
        bit do_pop;
        fifo_entry_t e;
        do_push = wr_valid && (model_q.size() < DEPTH) && !flush;
        do_pop  = (model_q.size() > 0) && rd_ready && !flush;
        if (reset || flush) begin
            model_q.delete();
            model_err = 1'b0;
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.error = wr_error;
                e.last  = wr_last;
                e.data  = wr_data;
                model_q.push_back(e);
                if (wr_error) model_err = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_rd_valid", 64'(rd_valid), 64'(model_q.size() != 0));
            check("m_wr_ready", 64'(wr_ready), 64'(model_q.size() != DEPTH));
            check("m_count",    64'(count),    64'(model_q.size()));
            check("m_err_seen", 64'(err_seen), 64'(model_err));
            check("m_burst",    64'(burst_cnt), BURST_EN ? 64'(model_bursts()) : 64'd0);
            if (model_q.size() != 0) begin
                check("m_rd_data",  rd_data,         model_q[0].data);
                check("m_rd_last",  64'(rd_last),    64'(model_q[0].last));
                check("m_rd_error", 64'(rd_error),   64'(model_q[0].error));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        wr_error = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic push(input logic [63:0] d, input bit last, input bit err);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        wr_error = err;
        step();
        idle();
    endtask

    task automatic pop_expect(input string name, input logic [63:0] d, input bit last);
        check({name, "_valid"}, 64'(rd_valid), 64'd1);
        check({name, "_data"},  rd_data,       d);
        check({name, "_last"},  64'(rd_last),  64'(last));
        rd_ready = 1'b1;
        step();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        model_err = 1'b0;
        step();
        step();
        reset = 1'b0;
        cmp_en = 1'b1;
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd1);
        check("rst_count",    64'(count),    64'd0);
        check("rst_err_seen", 64'(err_seen), 64'd0);
        check("rst_burst",    64'(burst_cnt), 64'd0);

        // 1: fill, then drain in order
        for (int i = 0; i < 4; i++) push(64'hA0 + 64'(i), i == 3, 1'b0);
        check("t1_wr_ready", 64'(wr_ready), 64'd0);
        check("t1_count",    64'(count),    64'd4);
        check("t1_burst",    64'(burst_cnt), BURST_EN ? 64'd1 : 64'd0);
        for (int i = 0; i < 4; i++) pop_expect("t1_pop", 64'hA0 + 64'(i), i == 3);
        check("t1_count_end", 64'(count),    64'd0);
        check("t1_rd_valid",  64'(rd_valid), 64'd0);
        check("t1_burst_end", 64'(burst_cnt), 64'd0);

        // 2: full with simultaneous push/pop refuses the push
        for (int i = 0; i < 4; i++) push(64'hB0 + 64'(i), 1'b0, 1'b0);
        wr_valid = 1'b1;
        wr_data  = 64'hC0;
        rd_ready = 1'b1;
        step();
        check("t2_count3", 64'(count), 64'd3);
        rd_ready = 1'b0;
        step();
        idle();
        check("t2_count4", 64'(count), 64'd4);
        pop_expect("t2_pop", 64'hB1, 1'b0);
        pop_expect("t2_pop", 64'hB2, 1'b0);
        pop_expect("t2_pop", 64'hB3, 1'b0);
        pop_expect("t2_pop", 64'hC0, 1'b0);

        // 3: one cycle of latency through an empty FIFO
        wr_valid = 1'b1;
        wr_data  = 64'h55;
        #1;
        check("t3_same_cycle", 64'(rd_valid), 64'd0);
        step();
        idle();
        check("t3_rd_valid", 64'(rd_valid), 64'd1);
        check("t3_rd_data",  rd_data,       64'h55);
        pop_expect("t3_pop", 64'h55, 1'b0);

        // 4: sticky error survives pops, cleared by flush
        push(64'h10, 1'b0, 1'b1);
        push(64'h11, 1'b0, 1'b0);
        push(64'h12, 1'b1, 1'b0);
        check("t4_err_seen", 64'(err_seen), 64'd1);
        for (int i = 0; i < 3; i++) begin
            rd_ready = 1'b1;
            step();
        end
        idle();
        check("t4_err_after_pops", 64'(err_seen), 64'd1);
        push(64'h13, 1'b1, 1'b0);
        flush = 1'b1;
        step();
        idle();
        check("t4_flush_count", 64'(count),    64'd0);
        check("t4_flush_err",   64'(err_seen), 64'd0);
        check("t4_flush_valid", 64'(rd_valid), 64'd0);

        // 5: flush wins over a concurrent push
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 64'h77;
        wr_error = 1'b1;
        step();
        idle();
        check("t5_count",    64'(count),    64'd0);
        check("t5_err_seen", 64'(err_seen), 64'd0);
        step();
        check("t5_rd_valid", 64'(rd_valid), 64'd0);

        // reset mid-burst
        push(64'h21, 1'b0, 1'b1);
        push(64'h22, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_count", 64'(count),     64'd0);
        check("rst_mid_burst", 64'(burst_cnt), 64'd0);
        check("rst_mid_err",   64'(err_seen),  64'd0);

        // random traffic, checked every cycle by the model compare
        for (int n = 0; n < 10000; n++) begin
            wr_valid = ($urandom_range(0, 99) < 60);
            rd_ready = ($urandom_range(0, 99) < 55);
            wr_data  = {$urandom, $urandom};
            wr_last  = ($urandom_range(0, 3) == 0);
            wr_error = ($urandom_range(0, 15) == 0);
            flush    = ($urandom_range(0, 127) == 0);
            reset    = ($urandom_range(0, 511) == 0);
            step();
        end
        idle();
        reset = 1'b0;
        step();
        step();
        cmp_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
